fetch_decode_pipe: RTL and testbench

- Owns the PC register, the instruction-memory fetch interface, and the IF/DE pipeline register of the Otter 5-stage pipeline.
- Consumes the hazard unit's `load_use_haz` / `control_haz` and the EX-stage redirect (`pc_source` plus targets).
- Produces the DE-stage instruction and PC, plus a bubble request for the DE/EX register.
- Holds a replay copy of the fetched instruction so stalls survive the synchronous instruction memory.

---
 rtl/otter_pipe_pkg.sv | 14 +
 rtl/fetch_decode_pipe_chk.sv | 14 +
 rtl/fetch_decode_pipe_pc_next_mux.sv | 29 ++
 rtl/fetch_decode_pipe.sv | 119 +++++++++++
 tb/tb_fetch_decode_pipe.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the Otter pipeline front end.
package otter_pipe_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_JALR   = 2'b01,
    PC_BRANCH = 2'b10,
    PC_JAL    = 2'b11
  } pc_src_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_decode_pipe_chk.sv
// Protocol checker: the hazard unit only selects a redirect while it also flushes.
module fetch_decode_pipe_chk (
  input logic       clk_i,
  input logic       rst_n_i,
  input logic [1:0] pc_source_i,
  input logic       control_haz_i
);

  a_redirect_only_on_flush: assert property (
    @(posedge clk_i) disable iff (!rst_n_i)
      (pc_source_i != 2'b00) |-> control_haz_i
  );

endmodule

// File: rtl/fetch_decode_pipe_pc_next_mux.sv
// Next-PC selector: sequential pc+4 or one of the three EX-stage redirect targets.
module pc_next_mux
  import otter_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  pc_src_t         sel_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [XLEN-1:0] jalr_target_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] jal_target_i,
  output logic [XLEN-1:0] next_pc_o
);

  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  // Route the selected source to the PC register input
  always_comb begin
    next_pc_o = pc_plus4_i;
    case (sel_i)
      PC_PLUS4:  next_pc_o = pc_plus4_i;
      PC_JALR:   next_pc_o = jalr_target_i & JALR_MASK;
      PC_BRANCH: next_pc_o = branch_target_i;
      PC_JAL:    next_pc_o = jal_target_i;
      default:   next_pc_o = pc_plus4_i;
    endcase
  end

endmodule

// File: rtl/fetch_decode_pipe.sv
// PC register, instruction fetch and IF/DE pipeline register of the Otter pipeline.
// A replay copy of the fetched word keeps DE stable across stalls of the synchronous imem.
module fetch_decode_pipe
  import otter_pipe_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_source,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jal_target,
  input  logic            load_use_haz,
  input  logic            control_haz,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_rden,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] de_pc,
  output logic [XLEN-1:0] de_pc4,
  output logic [31:0]     de_ir,
  output logic            de_valid,
  output logic            ex_bubble
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] de_pc_q,     de_pc_d;
  logic            de_valid_q,  de_valid_d;
  logic            hold_valid_q, hold_valid_d;
  logic [31:0]     hold_ir_q,   hold_ir_d;
  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] next_pc_s;

  assign pc_plus4_s = pc_q + PC_STEP;

  pc_next_mux #(.XLEN(XLEN)) u_pc_next_mux (
    .sel_i           (pc_src_t'(pc_source)),
    .pc_plus4_i      (pc_plus4_s),
    .jalr_target_i   (jalr_target),
    .branch_target_i (branch_target),
    .jal_target_i    (jal_target),
    .next_pc_o       (next_pc_s)
  );

  // Next-state: flush beats stall beats normal advance
  always_comb begin
    pc_d         = pc_q;
    de_pc_d      = de_pc_q;
    de_valid_d   = de_valid_q;
    hold_valid_d = hold_valid_q;
    hold_ir_d    = hold_ir_q;
    if (control_haz) begin
      pc_d         = next_pc_s;
      de_valid_d   = 1'b0;
      hold_valid_d = 1'b0;
    end else if (load_use_haz) begin
      // Capture only once: later stall cycles see the word after the held one
      if (!hold_valid_q) begin
        hold_ir_d    = imem_rdata;
        hold_valid_d = 1'b1;
      end else begin
        hold_ir_d    = hold_ir_q;
        hold_valid_d = 1'b1;
      end
    end else begin
      pc_d         = next_pc_s;
      de_pc_d      = pc_q;
      de_valid_d   = 1'b1;
      hold_valid_d = 1'b0;
    end
  end

  // Pipeline state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      de_pc_q      <= '0;
      de_valid_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_ir_q    <= NOP_INSTR;
    end else begin
      pc_q         <= pc_d;
      de_pc_q      <= de_pc_d;
      de_valid_q   <= de_valid_d;
      hold_valid_q <= hold_valid_d;
      hold_ir_q    <= hold_ir_d;
    end
  end

  // DE instruction: replay copy during/after a stall, else the live imem word
  always_comb begin
    de_ir = NOP_INSTR;
    if (!de_valid_q) begin
      de_ir = NOP_INSTR;
    end else if (hold_valid_q) begin
      de_ir = hold_ir_q;
    end else begin
      de_ir = imem_rdata;
    end
  end

  assign imem_addr = pc_q;
  assign imem_rden = rst_n;
  assign de_pc     = de_pc_q;
  assign de_pc4    = de_pc_q + PC_STEP;
  assign de_valid  = de_valid_q;
  assign ex_bubble = control_haz | load_use_haz;

  fetch_decode_pipe_chk u_chk (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .pc_source_i   (pc_source),
    .control_haz_i (control_haz)
  );

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Bench for fetch_decode_pipe: synchronous imem model, instruction-level reference model
// compared every cycle, plus directed literal expectations.
module tb_fetch_decode_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pc_source = 2'b00;
  logic [31:0] jalr_target = 32'h0, branch_target = 32'h0, jal_target = 32'h0;
  logic        load_use_haz = 1'b0, control_haz = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rden;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] de_pc, de_pc4, de_ir;
  logic        de_valid, ex_bubble;

  int checks = 0;
  int failures = 0;

  fetch_decode_pipe #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_source(pc_source),
    .jalr_target(jalr_target), .branch_target(branch_target), .jal_target(jal_target),
    .load_use_haz(load_use_haz), .control_haz(control_haz),
    .imem_addr(imem_addr), .imem_rden(imem_rden), .imem_rdata(imem_rdata),
    .de_pc(de_pc), .de_pc4(de_pc4), .de_ir(de_ir), .de_valid(de_valid), .ex_bubble(ex_bubble)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h00A0_0113;
      32'h0000_0008: mem_word = 32'h0000_A183;
      default:       mem_word = {a[29:0], 2'b11} ^ 32'h00C0_FFEE;
    endcase
  endfunction

  // synchronous instruction memory
  always @(posedge clk) if (imem_rden) imem_rdata <= mem_word(imem_addr);

  // reference model: architectural PC and the instruction sitting in DE
  logic [31:0] m_pc = 32'h0, m_de_pc = 32'h0;
  logic        m_de_valid = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_de_pc <= 32'h0; m_de_valid <= 1'b0;
    end else if (control_haz) begin
      case (pc_source)
        2'b01:   m_pc <= {jalr_target[31:1], 1'b0};
        2'b10:   m_pc <= branch_target;
        2'b11:   m_pc <= jal_target;
        default: m_pc <= m_pc + 32'd4;
      endcase
      m_de_valid <= 1'b0;
    end else if (!load_use_haz) begin
      m_de_pc <= m_pc; m_de_valid <= 1'b1; m_pc <= m_pc + 32'd4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_imem_rden", {31'b0, imem_rden}, {31'b0, rst_n});
    chk("m_de_pc", de_pc, m_de_pc);
    chk("m_de_pc4", de_pc4, m_de_pc + 32'd4);
    chk("m_de_valid", {31'b0, de_valid}, {31'b0, m_de_valid});
    chk("m_de_ir", de_ir, m_de_valid ? mem_word(m_de_pc) : NOP);
    chk("m_ex_bubble", {31'b0, ex_bubble}, {31'b0, control_haz | load_use_haz});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    step(2);
    #1;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_rden", {31'b0, imem_rden}, 32'h0);
    chk("rst_valid", {31'b0, de_valid}, 32'h0);
    chk("rst_ir", de_ir, NOP);
    rst_n = 1'b1;

    step(1);
    chk("c1_pc", de_pc, 32'h0);
    chk("c1_ir", de_ir, 32'h0050_0093);
    chk("c1_valid", {31'b0, de_valid}, 32'h1);
    step(1);
    chk("c2_pc", de_pc, 32'h4);
    chk("c2_ir", de_ir, 32'h00A0_0113);
    chk("c2_addr", imem_addr, 32'h8);
    step(1);
    chk("c3_pc", de_pc, 32'h8);
    chk("c3_ir", de_ir, 32'h0000_A183);

    // two-cycle load-use stall
    load_use_haz = 1'b1;
    #1 chk("st0_bubble", {31'b0, ex_bubble}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      step(1);
      chk("st_pc", de_pc, 32'h8);
      chk("st_ir", de_ir, 32'h0000_A183);
      chk("st_addr", imem_addr, 32'hC);
      chk("st_bubble", {31'b0, ex_bubble}, 32'h1);
    end
    load_use_haz = 1'b0;
    #1 chk("rel_ir", de_ir, 32'h0000_A183);
    step(1);
    chk("rel_pc", de_pc, 32'hC);

    // branch flush
    control_haz = 1'b1; pc_source = 2'b10; branch_target = 32'h40;
    #1 chk("fl_bubble", {31'b0, ex_bubble}, 32'h1);
    step(1);
    control_haz = 1'b0; pc_source = 2'b00;
    chk("fl_addr", imem_addr, 32'h40);
    chk("fl_valid", {31'b0, de_valid}, 32'h0);
    chk("fl_ir", de_ir, NOP);
    step(1);
    chk("fl2_pc", de_pc, 32'h40);
    chk("fl2_valid", {31'b0, de_valid}, 32'h1);

    // flush and stall together, jalr with odd target
    control_haz = 1'b1; load_use_haz = 1'b1; pc_source = 2'b01; jalr_target = 32'h81;
    #1 chk("both_bubble", {31'b0, ex_bubble}, 32'h1);
    step(1);
    control_haz = 1'b0; load_use_haz = 1'b0; pc_source = 2'b00;
    chk("both_addr", imem_addr, 32'h80);
    chk("both_valid", {31'b0, de_valid}, 32'h0);
    chk("both_hold", {31'b0, dut.hold_valid_q}, 32'h0);
    step(1);

    // PC wrap at the top of the address space
    control_haz = 1'b1; pc_source = 2'b11; jal_target = 32'hFFFF_FFFC;
    step(1);
    control_haz = 1'b0; pc_source = 2'b00;
    chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    step(1);
    chk("wr_addr", imem_addr, 32'h0);
    chk("wr_pc", de_pc, 32'hFFFF_FFFC);
    chk("wr_pc4", de_pc4, 32'h0);
    step(1);

    // async reset in the middle of a three-cycle stall
    load_use_haz = 1'b1;
    step(2);
    chk("ar_hold_pre", {31'b0, dut.hold_valid_q}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_valid", {31'b0, de_valid}, 32'h0);
    chk("ar_hold", {31'b0, dut.hold_valid_q}, 32'h0);
    chk("ar_rden", {31'b0, imem_rden}, 32'h0);
    load_use_haz = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("rs_pc", de_pc, 32'h0);
    chk("rs_ir", de_ir, 32'h0050_0093);
    step(1);
    chk("rs2_ir", de_ir, 32'h00A0_0113);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
